// File: rtl/bcd_conv_arbiter.sv
// Time-shared 16-bit binary-to-BCD converter (shift-and-add-3, one bit per clock)
// serving two requesters through a round-robin arbiter.
module bcd_conv_arbiter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [WIDTH-1:0]      data0,
    input  logic                  req1,
    input  logic [WIDTH-1:0]      data1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  valid0,
    output logic                  valid1,
    output logic                  owner
);
    localparam int BW = 4 * DIGITS;
    localparam int RW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state, state_nx;
    logic [RW-1:0]   work;
    logic [RW-1:0]   adj;
    logic [CW-1:0]   cnt;
    logic            last_grant;
    logic            pick;
    logic            accept;
    logic            last_iter;

    // Digit corrections are taken from the pre-shift value; no carry crosses a digit.
    genvar d;
    generate
        for (d = 0; d < DIGITS; d++) begin : g_digit
            assign adj[WIDTH+4*d +: 4] = (work[WIDTH+4*d +: 4] >= 4'd5) ?
                                         work[WIDTH+4*d +: 4] + 4'd3 :
                                         work[WIDTH+4*d +: 4];
        end
    endgenerate
    assign adj[WIDTH-1:0] = work[WIDTH-1:0];

    assign pick      = (req0 && req1) ? ~last_grant : req1;
    assign accept    = (state == IDLE) && (req0 || req1);
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign busy      = (state == SHIFT);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SHIFT;
            SHIFT:   if (last_iter) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            work       <= '0;
            cnt        <= '0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            valid0     <= 1'b0;
            valid1     <= 1'b0;
            bcd_out    <= '0;
        end else begin
            state  <= state_nx;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            valid0 <= 1'b0;
            valid1 <= 1'b0;
            if (accept) begin
                work       <= {{BW{1'b0}}, (pick ? data1 : data0)};
                owner      <= pick;
                last_grant <= pick;
                gnt0       <= ~pick;
                gnt1       <= pick;
                cnt        <= '0;
            end else if (state == SHIFT) begin
                work <= {adj[RW-2:0], 1'b0};
                cnt  <= cnt + 1'b1;
                // Upper digits of the post-shift register are the result.
                if (last_iter) begin
                    bcd_out <= adj[RW-2 -: BW];
                    valid0  <= ~owner;
                    valid1  <= owner;
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter: stimulus pushes expected results,
// a negedge monitor pops and compares on every valid pulse.
module tb_bcd_conv_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [15:0] data0, data1;
    logic        gnt0, gnt1, busy, valid0, valid1, owner;
    logic [19:0] bcd_out;

    int checks = 0;
    int failures = 0;
    logic [20:0] sbq[$];
    logic [20:0] e;
    logic        prev_busy = 1'b0;

    bcd_conv_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .bcd_out(bcd_out),
        .valid0(valid0), .valid1(valid1), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (valid0 || valid1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("valid_select", {30'd0, valid1, valid0}, e[20] ? 2 : 1);
                    chk("bcd_out", {12'd0, bcd_out}, {12'd0, e[19:0]});
                    chk("owner", {31'd0, owner}, {31'd0, e[20]});
                end
                chk("valid_gnt_overlap", {31'd0, gnt0 | gnt1}, 0);
            end
            if (gnt0 || gnt1) chk("gnt_while_busy", {31'd0, prev_busy}, 0);
        end
        prev_busy = busy;
    end

    task automatic run_one(input bit who, input logic [15:0] d, input logic [19:0] exp);
        int n;
        bit bad_busy;
        @(posedge clk); #1;
        if (who) begin req1 = 1'b1; data1 = d; end
        else     begin req0 = 1'b1; data0 = d; end
        sbq.push_back({who, exp});
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!(who ? gnt1 : gnt0) && n < 40);
        chk("grant_seen", {31'd0, who ? gnt1 : gnt0}, 1);
        chk("grant_latency", n, 1);
        chk("other_gnt", {31'd0, who ? gnt0 : gnt1}, 0);
        req0 = 1'b0; req1 = 1'b0;
        n = 0; bad_busy = 1'b0;
        do begin
            if (!busy) bad_busy = 1'b1;
            @(posedge clk); #1; n++;
        end while (!(valid0 || valid1) && n < 40);
        chk("valid_latency", n, 16);
        chk("busy_during", {31'd0, bad_busy}, 0);
        chk("busy_after", {31'd0, busy}, 0);
    endtask

    initial begin
        int n;
        bit saw, bad;
        int order[$];
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_gnt", {30'd0, gnt1, gnt0}, 0);
        chk("rst_valid", {30'd0, valid1, valid0}, 0);
        chk("rst_bcd", {12'd0, bcd_out}, 0);
        chk("rst_owner", {31'd0, owner}, 0);
        rst = 1'b0;

        run_one(1'b0, 16'd1234,  20'h01234);
        run_one(1'b0, 16'd65535, 20'h65535);
        run_one(1'b1, 16'd0,     20'h00000);
        run_one(1'b0, 16'd10000, 20'h10000);

        // Re-reset so the tie sees last_grant=1
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        chk("rst2_bcd", {12'd0, bcd_out}, 0);
        rst = 1'b0;

        // Tie: req0 wins, req1 granted at E17
        @(posedge clk); #1;
        req0 = 1'b1; data0 = 16'd42; req1 = 1'b1; data1 = 16'd9999;
        sbq.push_back({1'b0, 20'h00042});
        sbq.push_back({1'b1, 20'h09999});
        @(posedge clk); #1;
        chk("tie_gnt0", {31'd0, gnt0}, 1);
        chk("tie_gnt1", {31'd0, gnt1}, 0);
        req0 = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!gnt1 && n < 40);
        chk("tie_gnt1_edge", n, 17);
        req1 = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!valid1 && n < 40);
        chk("tie_valid1_latency", n, 16);

        // Fairness: both held for 6 conversions
        @(posedge clk); #1;
        data0 = 16'd2024; data1 = 16'd31415;
        for (int k = 0; k < 6; k++)
            sbq.push_back((k % 2) ? {1'b1, 20'h31415} : {1'b0, 20'h02024});
        req0 = 1'b1; req1 = 1'b1;
        n = 0;
        while (order.size() < 6 && n < 200) begin
            @(posedge clk); #1; n++;
            if (gnt0) order.push_back(0);
            if (gnt1) order.push_back(1);
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("fair_count", order.size(), 6);
        for (int k = 0; k < order.size(); k++) chk("fair_order", order[k], k % 2);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!valid1 && n < 40);
        chk("fair_last_valid", {31'd0, valid1}, 1);

        // Busy rejection: req1 pulsed during a req0 conversion
        @(posedge clk); #1;
        req0 = 1'b1; data0 = 16'd500;
        sbq.push_back({1'b0, 20'h00500});
        @(posedge clk); #1;
        chk("rej_gnt0", {31'd0, gnt0}, 1);
        req0 = 1'b0;
        saw = 1'b0; bad = 1'b0;
        for (int i = 1; i < 16; i++) begin
            @(posedge clk); #1;
            if (i == 3) begin req1 = 1'b1; data1 = 16'd123; end
            if (i == 6) req1 = 1'b0;
            if (gnt1) saw = 1'b1;
            if (bcd_out !== 20'h31415) bad = 1'b1;
        end
        @(posedge clk); #1;
        chk("rej_valid0", {31'd0, valid0}, 1);
        @(posedge clk); #1;
        if (gnt1) saw = 1'b1;
        chk("rej_no_gnt1", {31'd0, saw}, 0);
        chk("rej_bcd_hold", {31'd0, bad}, 0);

        // Reset abort in the middle of a conversion
        @(posedge clk); #1;
        req0 = 1'b1; data0 = 16'd4321;
        @(posedge clk); #1;
        chk("abort_gnt0", {31'd0, gnt0}, 1);
        req0 = 1'b0;
        repeat (7) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_gnt", {30'd0, gnt1, gnt0}, 0);
        chk("abort_valid", {30'd0, valid1, valid0}, 0);
        chk("abort_bcd", {12'd0, bcd_out}, 0);
        chk("abort_owner", {31'd0, owner}, 0);
        rst = 1'b0;
        saw = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (valid0 || valid1) saw = 1'b1;
        end
        chk("abort_no_valid", {31'd0, saw}, 0);

        run_one(1'b1, 16'd777, 20'h00777);

        repeat (2) @(posedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
Shared sequential binary-to-BCD conversion engine with a two-requester round-robin arbiter.
- Each accepted request converts one 16-bit unsigned value into 5 BCD digits (0..65535) using shift-and-add-3, one iteration per clock.
- The block serves producers that need decimal output, such as the display driver and the serial/UART formatter. It replaces duplicated combinational converters with one time-shared unit.

Parameters:
- WIDTH, 16, binary input width; the block is specified and verified only at 16.
- DIGITS, 5, BCD output digits; the block is specified and verified only at 5.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req0  in  1  requester 0 conversion request (level).
- data0  in  16  requester 0 binary operand.
- req1  in  1  requester 1 conversion request (level).
- data1  in  16  requester 1 binary operand.
- gnt0  out  1  one-cycle pulse: requester 0 accepted, data0 captured.
- gnt1  out  1  one-cycle pulse: requester 1 accepted, data1 captured.
- busy  out  1  high while a conversion is in progress.
- bcd_out  out  20  result; [19:16] = ten-thousands digit … [3:0] = units digit.
- valid0  out  1  one-cycle pulse: bcd_out holds requester 0 result.
- valid1  out  1  one-cycle pulse: bcd_out holds requester 1 result.
- owner  out  1  requester index of the current or last conversion.

Behaviour:
- Reset (rst=1 at a posedge):
  - State goes to IDLE. gnt0, gnt1, valid0, valid1, busy and bcd_out are 0; owner=0.
  - The shift register and iteration counter are 0. last_grant=1, so requester 0 wins the first tie.
  - A reset mid-conversion aborts it: no valid pulse, no partial result appears on bcd_out.
- States: IDLE, SHIFT. busy = (state==SHIFT), registered.
- IDLE, at posedge E0:
  - If req0 or req1 is high, arbitrate.
  - If only one is requesting, grant it.
  - If both are requesting, grant the one that is not last_grant.
  - Load the 36-bit working register as {20'b0, data_sel}. Set owner and last_grant. Pulse the matching gnt for the cycle after E0. Set counter=0 and go to SHIFT.
  - If neither is requesting, stay in IDLE.
- SHIFT, at posedges E1..E16, each edge performs one iteration:
  - Every 4-bit digit field of the upper 20 bits that is >=5 gets +3, all fields in parallel on the same pre-shift value.
  - The whole 36-bit register then shifts left by 1.
  - counter increments.
- At E16 (counter reaches 16):
  - bcd_out <= upper 20 bits after the final shift.
  - The matching valid pulses for one cycle.
  - State returns to IDLE.
- Latency: sampling edge E0 to valid high is 16 edges; valid is visible in the cycle after E16. The earliest next accept is E17. Throughput is one conversion per 17 cycles while requests are continuous.
- Requests seen while busy are ignored (no queueing). The requester keeps req and data stable until it sees its gnt. data is don't-care after the grant edge.
- req still high in the cycle after gnt counts as a new request and is arbitrated at the next IDLE edge.
- Round-robin: with both requesters held high continuously, grants strictly alternate.
- bcd_out holds its last value between conversions; it changes only on a completion edge or reset.
- Digit adds never carry across digit boundaries. For 16-bit input, no digit exceeds 9 and there is no overflow.
- A valid pulse and a new grant never occur in the same cycle.

Test Plan:
- Single conversion: reset, then req0=1, data0=16'd1234 sampled at E0 → gnt0 high in cycle E0+1 only; busy high E0+1..E16; valid0 high in cycle E16+1 only; bcd_out=20'h01234; owner=0.
- Boundaries: data0=16'd65535 → bcd_out=20'h65535. data1=16'd0 → bcd_out=20'h00000 with valid1 pulse. data0=16'd10000 → 20'h10000.
- Tie after reset: req0 (data0=16'd42) and req1 (data1=16'd9999) rise together → req0 granted first with result 20'h00042. req1 is granted at E17 with result 20'h09999, valid1 17 cycles after valid0.
- Fairness: both requests held high for 6 conversions → grant order 0,1,0,1,0,1; no gnt is issued while busy=1.
- Busy rejection: req1 pulsed for 3 cycles during a req0 conversion → no gnt1; bcd_out unchanged until valid0.
- Reset abort: rst=1 at iteration 8 of data0=16'd4321 → next cycle all outputs 0, no valid pulse. A subsequent req1 with data1=16'd777 completes normally with 20'h00777.
